uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter that succeeds the fixed 8N1 transmitter. It adds the following:
- a parametrised input FIFO with a valid/ready handshake
- runtime baud divisor
- 5 to MAX_DATA_BITS data bits
- none/even/odd parity
- 1 or 2 stop bits

It sits between a bus-side producer (CPU regs, DMA) and the pad; back-to-back frames go out with no idle gap while the FIFO is non-empty.

---
 rtl/uart_tx_cfg.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//
// Runtime-configurable UART transmitter with an input FIFO.
//
// A producer pushes words through a valid/ready handshake into a small FIFO.
// The transmit FSM pops one word per frame and serialises it as:
// start bit, 5..MAX_DATA_BITS data bits (LSB first), optional parity bit,
// and one or two stop bits. Queued words are sent back-to-back with no idle
// gap. The frame format is sampled into shadow registers at the pop edge, so
// configuration changes never disturb a frame already in flight.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   baud_div     clocks per bit (0 behaves as 1)
//   data_bits    payload bits per frame (clamped to 5..MAX_DATA_BITS)
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop2        1 = two stop bits, 0 = one stop bit
//   s_valid      producer has a word
//   s_data       payload word, LSB first; bits at/above data_bits ignored
//   s_ready      FIFO can accept a word (low while in reset and when full)
//   tx_serial    serial line, idle high
//   tx_active    a frame is in progress
//   tx_done      one-cycle pulse at the end of every frame
//   fifo_level   current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4,
    parameter int DIV_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [3:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          s_valid,
    input  logic [MAX_DATA_BITS-1:0]      s_data,
    output logic                          s_ready,
    output logic                          tx_serial,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    MIN_BITS = 4'd5;
    localparam logic [3:0]    MAX_BITS = 4'(MAX_DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // FIFO storage and control
    logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     ready_q, ready_d;
    logic                     push;
    logic                     pop;

    // Transmit FSM
    logic [2:0]               state_q, state_d;
    logic                     ser_q, ser_d;
    logic                     act_q, act_d;
    logic                     done_q, done_d;
    logic [DIV_W-1:0]         cnt_q, cnt_d;
    logic [3:0]               idx_q, idx_d;
    logic                     stop_idx_q, stop_idx_d;
    logic                     bit_end;

    // Per-frame shadow of the payload and the frame format
    logic [MAX_DATA_BITS-1:0] buf_q;
    logic [DIV_W-1:0]         div_q;
    logic [3:0]               nbits_q;
    logic                     par_en_q;
    logic                     par_odd_q;
    logic                     stop2_q;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    function automatic logic [3:0] eff_bits(input logic [3:0] n);
        logic [3:0] r;
        if (n < MIN_BITS) begin
            r = MIN_BITS;
        end else if (n > MAX_BITS) begin
            r = MAX_BITS;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Select one payload bit; written as a loop so the index width never
    // has to match the payload width.
    function automatic logic bit_at(input logic [MAX_DATA_BITS-1:0] w,
                                    input logic [3:0]               i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < MAX_DATA_BITS; k++) begin
            if (4'(k) == i) begin
                b = w[k];
            end
        end
        return b;
    endfunction

    // XOR of the payload bits actually transmitted (bits below n).
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] w,
                                       input logic [3:0]               n);
        logic p;
        p = 1'b0;
        for (int k = 0; k < MAX_DATA_BITS; k++) begin
            if (4'(k) < n) begin
                p = p ^ w[k];
            end
        end
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // s_ready is a register, so the accept decision never depends
    // combinationally on s_valid; a full FIFO refuses a push even when a pop
    // happens in the same cycle.
    assign push    = s_valid & ready_q;
    assign bit_end = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        state_d    = state_q;
        ser_d      = ser_q;
        act_d      = act_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                ser_d = 1'b1;
                act_d = 1'b0;
                cnt_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    ser_d   = 1'b0;
                    act_d   = 1'b1;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    ser_d   = bit_at(buf_q, 4'd0);
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == nbits_q - 4'd1) begin
                        if (par_en_q) begin
                            ser_d   = par_odd_q ^ parity_of(buf_q, nbits_q);
                            state_d = S_PARITY;
                        end else begin
                            ser_d      = 1'b1;
                            stop_idx_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        ser_d = bit_at(buf_q, idx_q + 4'd1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    cnt_d      = '0;
                    ser_d      = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop2_q && !stop_idx_q) begin
                        // First of two stop bits finished; line stays high.
                        stop_idx_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (level_q != '0) begin
                            // Chain straight into the next start bit.
                            pop     = 1'b1;
                            ser_d   = 1'b0;
                            state_d = S_START;
                        end else begin
                            ser_d   = 1'b1;
                            act_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            default: begin
                ser_d   = 1'b1;
                act_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != FULL_LVL);
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ser_q      <= 1'b1;
            act_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            stop_idx_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            div_q      <= DIV_W'(1);
            nbits_q    <= MIN_BITS;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ser_q      <= ser_d;
            act_q      <= act_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            if (pop) begin
                div_q     <= eff_div(baud_div);
                nbits_q   <= eff_bits(data_bits);
                par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_odd_q <= (parity_mode == 2'b10);
                stop2_q   <= stop2;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data registers (no reset: only ever read after being written)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
        if (pop) begin
            buf_q <= mem_q[rd_ptr_q];
        end
    end

    assign s_ready    = ready_q;
    assign tx_serial  = ser_q;
    assign tx_active  = act_q;
    assign tx_done    = done_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
//
// Directed testbench for uart_tx_cfg. Each scenario task drives its stimulus
// and compares the line against hand-written frame bit patterns (one bit per
// frame cell, LSB = first cell on the line).
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int MAXB  = 9;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   baud_div;
    logic [3:0]      data_bits;
    logic [1:0]      parity_mode;
    logic            stop2;
    logic            s_valid;
    logic [MAXB-1:0] s_data;
    logic            s_ready;
    logic            tx_serial;
    logic            tx_active;
    logic            tx_done;
    logic [2:0]      fifo_level;

    int checks = 0;
    int errors = 0;

    logic cap_ser  [0:199];
    logic cap_done [0:199];
    logic cap_act  [0:199];

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .MAX_DATA_BITS(MAXB),
        .FIFO_DEPTH   (DEPTH),
        .DIV_W        (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .data_bits  (data_bits),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx_serial  (tx_serial),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    // Record n consecutive negedge samples of the outputs.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_ser[k]  = tx_serial;
            cap_done[k] = tx_done;
            cap_act[k]  = tx_active;
        end
    endtask

    // Caller is just after a posedge; the word is accepted at the next edge.
    task automatic push(input logic [MAXB-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [DW-1:0] div, input logic [3:0] nb,
                           input logic [1:0] pm, input logic st2);
        baud_div    = div;
        data_bits   = nb;
        parity_mode = pm;
        stop2       = st2;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL rst_serial got %b exp 1", tx_serial); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", tx_active); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", tx_done); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", s_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", s_ready); end
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL post_rst_serial got %b exp 1", tx_serial); end
    endtask

    task automatic test_8n1();
        logic [11:0] cells;
        int nd;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
        @(posedge clk); #1;
        push(9'h0A5);
        @(negedge clk);
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL 8n1_latency got %b exp 1", tx_serial); end
        capture(41);
        cells = 12'({1'b1, 8'hA5, 1'b0});
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (cap_ser[k] !== cells[k/4]) begin
                errors++; $display("FAIL 8n1_bit clk=%0d got %b exp %b", k, cap_ser[k], cells[k/4]);
            end
        end
        nd = 0;
        for (int k = 0; k < 41; k++) nd += int'(cap_done[k]);
        checks++; if (nd != 1) begin errors++; $display("FAIL 8n1_done_count got %0d exp 1", nd); end
        checks++; if (cap_done[40] !== 1'b1) begin errors++; $display("FAIL 8n1_done_pos got %b exp 1", cap_done[40]); end
        checks++; if (cap_act[39] !== 1'b1) begin errors++; $display("FAIL 8n1_active got %b exp 1", cap_act[39]); end
        checks++; if (cap_act[40] !== 1'b0) begin errors++; $display("FAIL 8n1_active_end got %b exp 0", cap_act[40]); end
    endtask

    task automatic test_even_stop2();
        logic [11:0] cells;
        set_cfg(16'd3, 4'd7, 2'b01, 1'b1);
        @(posedge clk); #1;
        push(9'h053);
        @(negedge clk);
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL e7_latency got %b exp 1", tx_serial); end
        capture(34);
        cells = 12'({2'b11, 1'b0, 7'b1010011, 1'b0});
        for (int k = 0; k < 33; k++) begin
            checks++;
            if (cap_ser[k] !== cells[k/3]) begin
                errors++; $display("FAIL e7_bit clk=%0d got %b exp %b", k, cap_ser[k], cells[k/3]);
            end
        end
        checks++; if (cap_done[32] !== 1'b0) begin errors++; $display("FAIL e7_done_early got %b exp 0", cap_done[32]); end
        checks++; if (cap_done[33] !== 1'b1) begin errors++; $display("FAIL e7_done_pos got %b exp 1", cap_done[33]); end
    endtask

    task automatic test_odd9();
        logic [11:0] cells;
        set_cfg(16'd2, 4'd9, 2'b10, 1'b0);
        @(posedge clk); #1;
        push(9'h1FF);
        @(negedge clk);
        capture(25);
        cells = {1'b1, 1'b0, 9'h1FF, 1'b0};
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_ser[k] !== cells[k/2]) begin
                errors++; $display("FAIL o9_ones_bit clk=%0d got %b exp %b", k, cap_ser[k], cells[k/2]);
            end
        end
        checks++; if (cap_done[24] !== 1'b1) begin errors++; $display("FAIL o9_ones_done got %b exp 1", cap_done[24]); end
        // data_bits above the maximum is clamped to 9
        set_cfg(16'd2, 4'd15, 2'b10, 1'b0);
        @(posedge clk); #1;
        push(9'h000);
        @(negedge clk);
        capture(25);
        cells = {1'b1, 1'b1, 9'h000, 1'b0};
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_ser[k] !== cells[k/2]) begin
                errors++; $display("FAIL o9_zero_bit clk=%0d got %b exp %b", k, cap_ser[k], cells[k/2]);
            end
        end
        checks++; if (cap_done[24] !== 1'b1) begin errors++; $display("FAIL o9_zero_done got %b exp 1", cap_done[24]); end
    endtask

    task automatic test_back_to_back();
        logic [MAXB-1:0] w [6];
        int  sent, ndone, nact, gapbad, fullbad, rdybad, maxlvl;
        logic rdy;
        w[0] = 9'h01; w[1] = 9'h82; w[2] = 9'h44; w[3] = 9'hC8; w[4] = 9'h10; w[5] = 9'hFF;
        sent = 0; ndone = 0; nact = 0; gapbad = 0; fullbad = 0; rdybad = 0; maxlvl = 0;
        set_cfg(16'd2, 4'd8, 2'b00, 1'b0);
        @(posedge clk); #1;
        fork
            begin
                int guard;
                guard = 0;
                s_valid = 1'b1;
                while (sent < 6 && guard < 300) begin
                    s_data = w[sent];
                    rdy = s_ready;
                    @(posedge clk); #1;
                    if (rdy) sent++;
                    guard++;
                end
                s_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 160; k++) begin
                    @(negedge clk);
                    if (tx_done) begin
                        ndone++;
                        if (ndone < 6 && tx_serial !== 1'b0) gapbad++;
                    end
                    if (tx_active) nact++;
                    if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
                    if (fifo_level == 3'd4 && s_ready) fullbad++;
                    if (fifo_level < 3'd4 && !s_ready) rdybad++;
                end
            end
        join
        checks++; if (sent != 6) begin errors++; $display("FAIL b2b_sent got %0d exp 6", sent); end
        checks++; if (ndone != 6) begin errors++; $display("FAIL b2b_done got %0d exp 6", ndone); end
        checks++; if (nact != 120) begin errors++; $display("FAIL b2b_active_cycles got %0d exp 120", nact); end
        checks++; if (gapbad != 0) begin errors++; $display("FAIL b2b_gap got %0d exp 0", gapbad); end
        checks++; if (maxlvl != 4) begin errors++; $display("FAIL b2b_maxlevel got %0d exp 4", maxlvl); end
        checks++; if (fullbad != 0) begin errors++; $display("FAIL b2b_ready_full got %0d exp 0", fullbad); end
        checks++; if (rdybad != 0) begin errors++; $display("FAIL b2b_ready_notfull got %0d exp 0", rdybad); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_level_end got %0d exp 0", fifo_level); end
    endtask

    task automatic test_baud_change();
        logic [11:0] ca, cb;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
        @(posedge clk); #1;
        push(9'h00F);
        push(9'h033);
        baud_div = 16'd2;
        capture(61);
        ca = 12'({1'b1, 8'h0F, 1'b0});
        cb = 12'({1'b1, 8'h33, 1'b0});
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (cap_ser[k] !== ca[k/4]) begin
                errors++; $display("FAIL baud_a_bit clk=%0d got %b exp %b", k, cap_ser[k], ca[k/4]);
            end
        end
        for (int k = 40; k < 60; k++) begin
            checks++;
            if (cap_ser[k] !== cb[(k-40)/2]) begin
                errors++; $display("FAIL baud_b_bit clk=%0d got %b exp %b", k, cap_ser[k], cb[(k-40)/2]);
            end
        end
        checks++; if (cap_done[40] !== 1'b1) begin errors++; $display("FAIL baud_a_done got %b exp 1", cap_done[40]); end
        checks++; if (cap_done[60] !== 1'b1) begin errors++; $display("FAIL baud_b_done got %b exp 1", cap_done[60]); end
        checks++; if (cap_act[40] !== 1'b1) begin errors++; $display("FAIL baud_active_chain got %b exp 1", cap_act[40]); end
    endtask

    task automatic test_midframe_reset();
        int bad;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
        @(posedge clk); #1;
        push(9'h011);
        push(9'h022);
        push(9'h033);
        push(9'h044);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mrst_pre_level got %0d exp 3", fifo_level); end
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL mrst_pre_active got %b exp 1", tx_active); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL mrst_serial got %b exp 1", tx_serial); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL mrst_active got %b exp 0", tx_active); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mrst_level got %0d exp 0", fifo_level); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b exp 0", s_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || fifo_level !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mrst_quiet got %0d exp 0", bad); end
        @(posedge clk); #1;
        push(9'h055);
        @(negedge clk);
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL mrst_new_latency got %b exp 1", tx_serial); end
        capture(41);
        checks++; if (cap_ser[0] !== 1'b0) begin errors++; $display("FAIL mrst_new_start got %b exp 0", cap_ser[0]); end
        checks++; if (cap_done[40] !== 1'b1) begin errors++; $display("FAIL mrst_new_done got %b exp 1", cap_done[40]); end
    endtask

    task automatic test_div0_clamp();
        logic [11:0] cells;
        set_cfg(16'd0, 4'd2, 2'b00, 1'b0);
        @(posedge clk); #1;
        push(9'h1F5);
        @(negedge clk);
        capture(8);
        cells = 12'({1'b1, 5'b10101, 1'b0});
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cap_ser[k] !== cells[k]) begin
                errors++; $display("FAIL div0_bit clk=%0d got %b exp %b", k, cap_ser[k], cells[k]);
            end
        end
        checks++; if (cap_done[6] !== 1'b0) begin errors++; $display("FAIL div0_done_early got %b exp 0", cap_done[6]); end
        checks++; if (cap_done[7] !== 1'b1) begin errors++; $display("FAIL div0_done got %b exp 1", cap_done[7]); end
        checks++; if (cap_ser[7] !== 1'b1) begin errors++; $display("FAIL div0_idle got %b exp 1", cap_ser[7]); end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
        test_reset();
        test_8n1();
        test_even_stop2();
        test_odd9();
        test_back_to_back();
        test_baud_change();
        test_midframe_reset();
        test_div0_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
